// File: rtl/vdp_pkg.sv
// Shared widths, FSM encoding and access descriptor for the VDP VRAM access path.
package vdp_pkg;
  localparam int VRAM_AW = 14;
  localparam int VRAM_DW = 8;

  localparam logic [1:0] CMD_RD = 2'b00;
  localparam logic [1:0] CMD_WR = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_CAPT = 2'd3
  } vram_st_e;

  typedef struct packed {
    logic               wr;
    logic [VRAM_AW-1:0] addr;
    logic [VRAM_DW-1:0] wdata;
  } vram_acc_t;
endpackage

// File: rtl/vdp_cpu_port.sv
// TMS9918-style CPU side: control byte toggle, auto-increment address,
// read-ahead latch, single queued VRAM access and register writes.
module vdp_cpu_port
  import vdp_pkg::*;
(
  input  logic               clk40m,
  input  logic               rst,
  input  logic               cpu_data_wr,
  input  logic               cpu_data_rd,
  input  logic               cpu_ctrl_wr,
  input  logic               cpu_status_rd,
  input  logic [7:0]         cpu_wdata,
  input  logic               gnt,
  input  logic               done,
  input  logic [VRAM_DW-1:0] rdata,
  output logic               pend,
  output vram_acc_t          acc,
  output logic [7:0]         cpu_rdata,
  output logic               cpu_busy,
  output logic               cpu_overrun,
  output logic               reg_wr,
  output logic [2:0]         reg_num,
  output logic [7:0]         reg_data
);
  logic               toggle;
  logic [7:0]         lo;
  logic [VRAM_AW-1:0] addr;
  logic [VRAM_AW-1:0] ctrl_addr;

  assign ctrl_addr = {cpu_wdata[5:0], lo};

  always_ff @(posedge clk40m) begin
    if (rst) begin
      toggle      <= 1'b0;
      lo          <= '0;
      addr        <= '0;
      pend        <= 1'b0;
      acc         <= '0;
      cpu_rdata   <= '0;
      cpu_busy    <= 1'b0;
      cpu_overrun <= 1'b0;
      reg_wr      <= 1'b0;
      reg_num     <= '0;
      reg_data    <= '0;
    end else begin
      cpu_overrun <= 1'b0;
      reg_wr      <= 1'b0;
      if (gnt) pend <= 1'b0;
      if (done) begin
        cpu_busy <= 1'b0;
        if (!acc.wr) cpu_rdata <= rdata;
      end
      if (cpu_ctrl_wr) begin
        if (!toggle) begin
          lo     <= cpu_wdata;
          toggle <= 1'b1;
        end else begin
          toggle <= 1'b0;
          if (cpu_wdata[7]) begin
            reg_wr   <= 1'b1;
            reg_num  <= cpu_wdata[2:0];
            reg_data <= lo;
          end else if (cpu_wdata[7:6] == CMD_WR) begin
            addr <= ctrl_addr;
          end else if (cpu_wdata[7:6] == CMD_RD) begin
            // Read setup while busy keeps the in-flight access; only A moves.
            if (cpu_busy) begin
              addr        <= ctrl_addr;
              cpu_overrun <= 1'b1;
            end else begin
              addr     <= ctrl_addr + 1'b1;
              pend     <= 1'b1;
              cpu_busy <= 1'b1;
              acc.wr   <= 1'b0;
              acc.addr <= ctrl_addr;
            end
          end
        end
      end else if (cpu_data_wr || cpu_data_rd) begin
        toggle <= 1'b0;
        if (cpu_busy) begin
          cpu_overrun <= 1'b1;
        end else begin
          pend     <= 1'b1;
          cpu_busy <= 1'b1;
          acc.wr   <= cpu_data_wr;
          acc.addr <= addr;
          addr     <= addr + 1'b1;
          if (cpu_data_wr) begin
            acc.wdata <= cpu_wdata;
            cpu_rdata <= cpu_wdata;
          end
        end
      end else if (cpu_status_rd) begin
        toggle <= 1'b0;
      end
    end
  end
endmodule

// File: rtl/vdp_vram_master.sv
// VRAM port initiator: arbitrates display fetch and CPU port onto a
// single-strobe SRAM controller interface (IDLE -> REQ -> WAIT -> CAPT).
module vdp_vram_master
  import vdp_pkg::*;
#(
  parameter int DISP_BURST = 4
) (
  input  logic               clk40m,
  input  logic               rst,
  input  logic               cpu_data_wr,
  input  logic               cpu_data_rd,
  input  logic               cpu_ctrl_wr,
  input  logic               cpu_status_rd,
  input  logic [7:0]         cpu_wdata,
  output logic [7:0]         cpu_rdata,
  output logic               cpu_busy,
  output logic               cpu_overrun,
  output logic               reg_wr,
  output logic [2:0]         reg_num,
  output logic [7:0]         reg_data,
  input  logic               disp_req,
  input  logic [VRAM_AW-1:0] disp_addr,
  output logic               disp_ack,
  output logic [VRAM_DW-1:0] disp_rdata,
  output logic               vram_req,
  output logic               vram_wr,
  input  logic               vram_ack,
  output logic [VRAM_AW-1:0] vram_addr,
  output logic [VRAM_DW-1:0] vram_wdata,
  input  logic [VRAM_DW-1:0] vram_rdata
);
  localparam int BCW = $clog2(DISP_BURST + 1);

  vram_st_e       state, state_nx;
  vram_acc_t      cpu_acc;
  logic           cpu_pend, gnt_disp, gnt_cpu, cur_cpu;
  logic           cpu_done, disp_done, burst_full;
  logic [BCW-1:0] burst;

  vdp_cpu_port u_cpu (
    .clk40m        (clk40m),
    .rst           (rst),
    .cpu_data_wr   (cpu_data_wr),
    .cpu_data_rd   (cpu_data_rd),
    .cpu_ctrl_wr   (cpu_ctrl_wr),
    .cpu_status_rd (cpu_status_rd),
    .cpu_wdata     (cpu_wdata),
    .gnt           (gnt_cpu),
    .done          (cpu_done),
    .rdata         (vram_rdata),
    .pend          (cpu_pend),
    .acc           (cpu_acc),
    .cpu_rdata     (cpu_rdata),
    .cpu_busy      (cpu_busy),
    .cpu_overrun   (cpu_overrun),
    .reg_wr        (reg_wr),
    .reg_num       (reg_num),
    .reg_data      (reg_data)
  );

  assign burst_full = (burst == BCW'(DISP_BURST));

  always_ff @(posedge clk40m) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  // The disp_ack cycle grants nobody: a display client that re-requests at
  // once must get its chance, otherwise the CPU would take every slot after
  // a display ack and the burst limit would never come into play.
  always_comb begin
    state_nx = state;
    gnt_disp = 1'b0;
    gnt_cpu  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (!disp_ack) begin
          if (disp_req && !(cpu_pend && burst_full)) gnt_disp = 1'b1;
          else if (cpu_pend)                         gnt_cpu  = 1'b1;
        end
        if (gnt_disp || gnt_cpu) state_nx = ST_REQ;
      end
      ST_REQ:  state_nx = ST_WAIT;
      ST_WAIT: if (vram_ack) state_nx = ST_CAPT;
      ST_CAPT: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    cpu_done  = (state == ST_CAPT) &&  cur_cpu;
    disp_done = (state == ST_CAPT) && !cur_cpu;
  end

  always_ff @(posedge clk40m) begin
    if (rst) begin
      vram_req   <= 1'b0;
      vram_wr    <= 1'b0;
      vram_addr  <= '0;
      vram_wdata <= '0;
      disp_ack   <= 1'b0;
      disp_rdata <= '0;
      cur_cpu    <= 1'b0;
      burst      <= '0;
    end else begin
      vram_req <= gnt_disp || gnt_cpu;
      disp_ack <= disp_done;
      if (disp_done) disp_rdata <= vram_rdata;
      if (gnt_disp) begin
        vram_wr   <= 1'b0;
        vram_addr <= disp_addr;
        cur_cpu   <= 1'b0;
        if (cpu_pend && !burst_full) burst <= burst + 1'b1;
      end
      if (gnt_cpu) begin
        vram_wr    <= cpu_acc.wr;
        vram_addr  <= cpu_acc.addr;
        vram_wdata <= cpu_acc.wdata;
        cur_cpu    <= 1'b1;
        burst      <= '0;
      end
    end
  end
endmodule

// File: tb/tb_vdp_vram_master.sv
// Scoreboard bench for vdp_vram_master: SRAM model acks 3 cycles after
// vram_req and returns addr[7:0] as read data.
module tb_vdp_vram_master;
  typedef struct packed {
    logic        wr;
    logic [13:0] addr;
    logic [7:0]  wdata;
  } exp_acc_t;

  logic        clk40m = 1'b0;
  logic        rst;
  logic        cpu_data_wr, cpu_data_rd, cpu_ctrl_wr, cpu_status_rd;
  logic [7:0]  cpu_wdata, cpu_rdata;
  logic        cpu_busy, cpu_overrun, reg_wr;
  logic [2:0]  reg_num;
  logic [7:0]  reg_data;
  logic        disp_req, disp_ack;
  logic [13:0] disp_addr;
  logic [7:0]  disp_rdata;
  logic        vram_req, vram_wr, vram_ack;
  logic [13:0] vram_addr;
  logic [7:0]  vram_wdata, vram_rdata;

  int checks = 0;
  int errors = 0;
  int disp_cnt = 0;

  exp_acc_t    exp_vram[$];
  logic [7:0]  exp_disp[$];
  logic [7:0]  exp_cpu[$];
  logic [10:0] exp_reg[$];

  always #10 clk40m = ~clk40m;

  vdp_vram_master #(.DISP_BURST(4)) dut (
    .clk40m(clk40m), .rst(rst),
    .cpu_data_wr(cpu_data_wr), .cpu_data_rd(cpu_data_rd),
    .cpu_ctrl_wr(cpu_ctrl_wr), .cpu_status_rd(cpu_status_rd),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_busy(cpu_busy),
    .cpu_overrun(cpu_overrun), .reg_wr(reg_wr), .reg_num(reg_num), .reg_data(reg_data),
    .disp_req(disp_req), .disp_addr(disp_addr), .disp_ack(disp_ack), .disp_rdata(disp_rdata),
    .vram_req(vram_req), .vram_wr(vram_wr), .vram_ack(vram_ack), .vram_addr(vram_addr),
    .vram_wdata(vram_wdata), .vram_rdata(vram_rdata)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // SRAM controller model
  logic [2:0]  p;
  logic [13:0] m_addr;
  assign vram_ack = p[2];
  always @(posedge clk40m) begin
    if (rst) begin
      p          <= '0;
      vram_rdata <= '0;
    end else begin
      p <= {p[1:0], vram_req};
      if (p[2])     vram_rdata <= m_addr[7:0];
      if (vram_req) m_addr     <= vram_addr;
    end
  end

  // Monitor
  logic        prev_req, prev_busy;
  logic [13:0] cap_addr;
  always @(negedge clk40m) begin
    exp_acc_t e;
    logic [10:0] r;
    if (rst) begin
      prev_req  = 1'b0;
      prev_busy = 1'b0;
    end else begin
      if (vram_req) begin
        chk("vram_req_single_cycle", prev_req, 1'b0);
        if (exp_vram.size() == 0) chk("vram_req_unexpected", vram_addr, 14'h3FFF ^ vram_addr ^ 14'h3FFF + 1'b1);
        else begin
          e = exp_vram.pop_front();
          chk("vram_wr", vram_wr, e.wr);
          chk("vram_addr", vram_addr, e.addr);
          if (e.wr) chk("vram_wdata", vram_wdata, e.wdata);
        end
        cap_addr = vram_addr;
      end
      if (vram_ack) chk("vram_addr_held", vram_addr, cap_addr);
      if (disp_ack) begin
        disp_cnt++;
        if (exp_disp.size() == 0) begin
          checks++; errors++;
          $display("FAIL disp_ack_unexpected actual=%0h required=none", disp_rdata);
        end else chk("disp_rdata", disp_rdata, exp_disp.pop_front());
      end
      if (reg_wr) begin
        if (exp_reg.size() == 0) begin
          checks++; errors++;
          $display("FAIL reg_wr_unexpected actual=%0h required=none", {reg_num, reg_data});
        end else begin
          r = exp_reg.pop_front();
          chk("reg_num", reg_num, r[10:8]);
          chk("reg_data", reg_data, r[7:0]);
        end
      end
      if (prev_busy && !cpu_busy) begin
        if (exp_cpu.size() == 0) begin
          checks++; errors++;
          $display("FAIL cpu_done_unexpected actual=%0h required=none", cpu_rdata);
        end else chk("cpu_rdata_done", cpu_rdata, exp_cpu.pop_front());
      end
      prev_req  = vram_req;
      prev_busy = cpu_busy;
    end
  end

  // kind: 0 ctrl, 1 data_wr, 2 data_rd
  task automatic strobe(input int kind, input logic [7:0] b);
    @(negedge clk40m);
    cpu_wdata = b;
    case (kind)
      0: cpu_ctrl_wr = 1'b1;
      1: cpu_data_wr = 1'b1;
      default: cpu_data_rd = 1'b1;
    endcase
    @(negedge clk40m);
    cpu_ctrl_wr = 1'b0;
    cpu_data_wr = 1'b0;
    cpu_data_rd = 1'b0;
  endtask

  task automatic wait_cpu(input string nm);
    int n = 0;
    while (cpu_busy && n < 40) begin
      @(negedge clk40m);
      n++;
    end
    chk(nm, cpu_busy, 1'b0);
  endtask

  task automatic wait_disp(input string nm, input int target);
    int n = 0;
    while (disp_cnt < target && n < 300) begin
      @(negedge clk40m);
      n++;
    end
    chk(nm, disp_cnt, target);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    logic any_req;
    int   n;
    rst = 1'b1;
    cpu_data_wr = 0; cpu_data_rd = 0; cpu_ctrl_wr = 0; cpu_status_rd = 0;
    cpu_wdata = '0; disp_req = 0; disp_addr = '0;

    // 1: reset
    repeat (3) @(negedge clk40m);
    chk("rst_vram_req", vram_req, 0);
    chk("rst_cpu_busy", cpu_busy, 0);
    chk("rst_cpu_rdata", cpu_rdata, 0);
    chk("rst_disp_ack", disp_ack, 0);
    chk("rst_outs", {vram_wr, vram_addr, vram_wdata, reg_wr, cpu_overrun, disp_rdata}, 0);
    rst = 1'b0;
    any_req = 1'b0;
    repeat (10) begin @(negedge clk40m); any_req |= vram_req; end
    chk("idle_no_req", any_req, 0);

    // 2: address 3FFF, two writes wrapping to 0000
    strobe(0, 8'hFF);
    strobe(0, 8'h7F);
    exp_vram.push_back('{1'b1, 14'h3FFF, 8'h5A}); exp_cpu.push_back(8'h5A);
    strobe(1, 8'h5A);
    chk("wr_rdata_immediate", cpu_rdata, 8'h5A);
    wait_cpu("busy_wr1");
    exp_vram.push_back('{1'b1, 14'h0000, 8'hA5}); exp_cpu.push_back(8'hA5);
    strobe(1, 8'hA5);
    wait_cpu("busy_wr2");
    chk("cpu_rdata_a5", cpu_rdata, 8'hA5);

    // 3: prefetch at 0000, then three reads
    strobe(0, 8'h00);
    exp_vram.push_back('{1'b0, 14'h0000, 8'h00}); exp_cpu.push_back(8'h00);
    strobe(0, 8'h00);
    wait_cpu("busy_prefetch");
    for (int k = 0; k < 3; k++) begin
      chk("rd_consumed", cpu_rdata, k);
      exp_vram.push_back('{1'b0, 14'(k + 1), 8'h00}); exp_cpu.push_back(8'(k + 1));
      strobe(2, 8'h00);
      wait_cpu("busy_rd");
    end

    // 4: register write, then toggle back at low byte
    exp_reg.push_back({3'd7, 8'h12});
    strobe(0, 8'h12);
    strobe(0, 8'h87);
    repeat (3) @(negedge clk40m);
    chk("reg_no_busy", cpu_busy, 0);
    strobe(0, 8'h34);
    strobe(0, 8'h41);
    exp_vram.push_back('{1'b1, 14'h0134, 8'h99}); exp_cpu.push_back(8'h99);
    strobe(1, 8'h99);
    wait_cpu("busy_after_reg");

    // 5: display burst limit with a CPU write pending
    strobe(0, 8'h40);
    strobe(0, 8'h41);
    for (int k = 0; k < 4; k++) begin
      exp_vram.push_back('{1'b0, 14'h0123, 8'h00}); exp_disp.push_back(8'h23);
    end
    exp_vram.push_back('{1'b1, 14'h0140, 8'h77}); exp_cpu.push_back(8'h77);
    exp_vram.push_back('{1'b0, 14'h0123, 8'h00}); exp_disp.push_back(8'h23);
    n = disp_cnt;
    strobe(1, 8'h77);
    disp_addr = 14'h0123;
    disp_req  = 1'b1;
    wait_disp("disp_burst_acks", n + 5);
    disp_req = 1'b0;
    wait_cpu("busy_burst");
    repeat (4) @(negedge clk40m);

    // 6: overrun
    strobe(0, 8'h00);
    strobe(0, 8'h42);
    exp_vram.push_back('{1'b1, 14'h0200, 8'h11}); exp_cpu.push_back(8'h11);
    strobe(1, 8'h11);
    chk("ovr_first_none", cpu_overrun, 0);
    strobe(1, 8'h22);
    chk("ovr_pulse", cpu_overrun, 1);
    @(negedge clk40m);
    chk("ovr_pulse_end", cpu_overrun, 0);
    chk("ovr_rdata_kept", cpu_rdata, 8'h11);
    wait_cpu("busy_ovr");
    exp_vram.push_back('{1'b1, 14'h0201, 8'h33}); exp_cpu.push_back(8'h33);
    strobe(1, 8'h33);
    wait_cpu("busy_ovr_next");

    // 7: reset during WAIT
    exp_vram.push_back('{1'b0, 14'h0055, 8'h00});
    disp_addr = 14'h0055;
    disp_req  = 1'b1;
    n = 0;
    while (!vram_req && n < 20) begin @(negedge clk40m); n++; end
    chk("rst_case_req_seen", vram_req, 1);
    repeat (2) @(negedge clk40m);
    rst = 1'b1;
    disp_req = 1'b0;
    repeat (2) @(negedge clk40m);
    chk("midrst_disp_ack", disp_ack, 0);
    chk("midrst_vram_req", vram_req, 0);
    chk("midrst_cpu_rdata", cpu_rdata, 0);
    rst = 1'b0;
    repeat (8) @(negedge clk40m);
    exp_vram.push_back('{1'b1, 14'h0000, 8'h66}); exp_cpu.push_back(8'h66);
    strobe(1, 8'h66);
    wait_cpu("busy_post_rst");
    exp_vram.push_back('{1'b0, 14'h0077, 8'h00}); exp_disp.push_back(8'h77);
    n = disp_cnt;
    disp_addr = 14'h0077;
    disp_req  = 1'b1;
    wait_disp("disp_post_rst", n + 1);
    disp_req = 1'b0;
    repeat (6) @(negedge clk40m);

    chk("left_vram", exp_vram.size(), 0);
    chk("left_disp", exp_disp.size(), 0);
    chk("left_cpu", exp_cpu.size(), 0);
    chk("left_reg", exp_reg.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
